// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a level lasting HIGH_TICKS timebase strobes,
// then forces GAP_TICKS strobes of low. Define PULSE_STRETCHER_RETRIGGER_EN to let
// a trigger during the high phase reload the count instead of flagging overrun.
module pulse_stretcher #(
    parameter int HIGH_TICKS = 10,
    parameter int GAP_TICKS  = 2,
    parameter int CW         = 8
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick_in,
    input  logic pulse_in,
    input  logic clr_overrun,
    output logic level_out,
    output logic busy,
    output logic overrun_out
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

    localparam logic [CW-1:0] HIGH_LD = CW'(HIGH_TICKS);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_TICKS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ovr_set;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ovr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = HIGH_LD;
                end
            end
            ACTIVE: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                // A retrigger beats a coincident final tick.
                if (pulse_in) begin
                    cnt_nxt = HIGH_LD;
                end else
`else
                ovr_set = pulse_in;
`endif
                if (tick_in) begin
                    if (cnt == ONE) begin
                        if (GAP_TICKS > 0) begin
                            state_nxt = HOLDOFF;
                            cnt_nxt   = GAP_LD;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else if (cnt > ONE) begin
                        cnt_nxt = cnt - ONE;
                    end
                end
            end
            HOLDOFF: begin
                ovr_set = pulse_in;
                if (tick_in) begin
                    if (cnt == ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt > ONE) begin
                        cnt_nxt = cnt - ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            level_out   <= 1'b0;
            busy        <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= (state_nxt == ACTIVE);
            busy      <= (state_nxt != IDLE);
            if (ovr_set)
                overrun_out <= 1'b1;
            else if (clr_overrun)
                overrun_out <= 1'b0;
        end
    end

endmodule
